ym_reg_sequencer: RTL
=====================

Name: ym_reg_sequencer

Overview:
- Timed register-write sequencer and Wishbone master that sits directly upstream of the PSG Wishbone slave.
- Accepts a stream of commands of two kinds: "write reg A with value D" or "wait N ticks".
- Buffers commands in a small FIFO and issues register writes as pipelined Wishbone single-write cycles, paced by a tick prescaler (e.g. 50 Hz frame rate), so CPU or DMA can queue whole tune frames.

Parameters:
- CLK_IN_HZ, 100000000, system clock frequency.
- TICK_HZ, 50, wait-tick rate. DIV = CLK_IN_HZ/TICK_HZ, must be >= 2; elaboration error otherwise.
- FIFO_DEPTH, 16, command FIFO entries, power of two >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept.
- cmd_wait  in  1  1 = wait command, 0 = register write.
- cmd_payload  in  16  wait: tick count N; write: [15:8] register address, [7:0] data.
- enable  in  1  sequencer runs when high.
- flush  in  1  one-cycle pulse: discard queued commands and any pending wait.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- wb_adr  out  8  register address.
- wb_dat_w  out  32  {24'b0, data}.
- wb_sel  out  4  constant 4'b0001 during cycles.
- wb_cyc, wb_stb, wb_we  out  1 each  Wishbone master controls.
- wb_ack, wb_err, wb_stall  in  1 each  Wishbone slave responses.
- wr_count  out  16  writes acked (stats).
- err_count  out  8  writes errored (stats).

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. FIFO is empty, FSM in IDLE, prescaler = 0.
- Push: on cmd_valid && cmd_ready, the 17-bit entry {cmd_wait, cmd_payload} is written to the FIFO. cmd_ready = (level < FIFO_DEPTH), registered. A pop in the same cycle as a full FIFO does not raise cmd_ready until the next cycle.
- Prescaler:
  - Counts 0..DIV-1 while enable is high and emits a one-cycle tick on wrap.
  - Held at 0 while enable is low, so the first tick after enable comes a full period later.
- FSM states: IDLE, WB_REQ, WB_WAIT, WAIT_TICKS.
  - IDLE with enable high and FIFO non-empty pops the head.
    - Write command: latch the address and data into registered bus outputs, raise cyc, stb and we, go to WB_REQ. wb_stb first appears 2 cycles after the accepting push into an empty FIFO.
    - Wait command with N > 0: load the wait counter with N, go to WAIT_TICKS.
    - Wait command with N = 0: consumed in one cycle, stay in IDLE.
  - WB_REQ: hold stb until a cycle with !wb_stall. Then drop stb on the next edge and go to WB_WAIT. An ack or err in that same cycle is accepted immediately (cyc and we drop, return to IDLE).
  - WB_WAIT: hold cyc until ack or err, then drop cyc and we and return to IDLE. Ack and err together count as err.
  - WAIT_TICKS: decrement on each tick. At 0, return to IDLE. The counter freezes while enable is low.
- One write per Wishbone cycle. cyc is never held across commands. At most one command is popped per IDLE visit, so back-to-back writes have at least one idle cycle between cycles.
- enable low:
  - An in-flight bus cycle (WB_REQ/WB_WAIT) still completes.
  - No new pop occurs.
  - WAIT_TICKS is paused, not aborted.
- flush:
  - Empties the FIFO and forces WAIT_TICKS to IDLE.
  - An in-flight bus cycle completes normally.
  - flush wins over a simultaneous push (that push is dropped, but cmd_ready was high so the producer sees it accepted; documented).
- Bus hang: no timeout. The slave must respond.
- rst mid-cycle drops cyc and stb immediately on the next edge.

Optional Feature:
- Macro YM_REG_SEQUENCER_STATS_EN.
- Defined:
  - wr_count increments on each ack-terminated write, saturating at 16'hFFFF.
  - err_count increments on each err-terminated write, saturating at 8'hFF.
  - Both cleared by rst.
- Undefined: both outputs tied to 0 and no counter logic is synthesised. Ports are always present.

Decomposition:
- Package ym_seq_pkg: state enum (IDLE, WB_REQ, WB_WAIT, WAIT_TICKS), cmd entry struct {wait, payload}, CMD_W = 17, WB_SEL_BYTE0 = 4'b0001.
- Sub-module ym_seq_fifo: synchronous FIFO with head read combinationally, level output, flush input.
- FSM, prescaler and bus logic live in the top.

Test Plan:
- After rst, push write {addr 8'h07, data 8'h38} with enable = 1 -> wb_stb high 2 cycles later with wb_adr = 8'h07, wb_dat_w = 32'h38, wb_sel = 4'b0001, wb_we = 1. The slave acks the next cycle -> cyc drops, wr_count = 1 (with macro).
- Slave asserts wb_stall for 3 cycles -> stb and address held stable all 3 cycles, stb drops after the first non-stalled cycle, exactly one transfer.
- CLK_IN_HZ = 1000, TICK_HZ = 100. Push write(0,1), wait(3), write(1,2) -> second stb starts 30±2 cycles after the first ack. wait(0) adds no tick delay.
- Push 16 commands with enable = 0 -> cmd_ready low, fifo_level = 16. A 17th push is not accepted. Raise enable -> all 16 drain in order.
- wb_err on a write -> err_count = 1, wr_count unchanged, sequencer proceeds to the next command.
- During WAIT_TICKS with 5 queued writes, pulse flush -> fifo_level = 0, busy low within 2 cycles, no further stb.

Source files
------------

// File: rtl/ym_seq_pkg.sv
// Shared types for the timed register-write sequencer: FSM states, queued command entry,
// and bus constants.
package ym_seq_pkg;

  localparam int         CMD_W        = 17;
  localparam logic [3:0] WB_SEL_BYTE0 = 4'b0001;

  typedef enum logic [1:0] {
    IDLE,
    WB_REQ,
    WB_WAIT,
    WAIT_TICKS
  } seq_state_e;

  // is_wait=1: payload is a tick count; is_wait=0: payload is {reg_addr, reg_data}
  typedef struct packed {
    logic        is_wait;
    logic [15:0] payload;
  } cmd_t;

endpackage

// File: rtl/ym_seq_fifo.sv
// Command FIFO: head is readable combinationally, push/pop take effect on the next edge,
// and flush empties it in one cycle. Callers never push when full or pop when empty.
module ym_seq_fifo
  import ym_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = CMD_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] level_nxt,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head      = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign level_nxt = level_d;
  assign empty     = (level_q == '0);

endmodule

// File: rtl/ym_reg_sequencer.sv
// Tick-paced register-write sequencer and Wishbone master; first stb 2 cycles after a push
// into an empty FIFO, cmd_ready drops when full. Stats counters need YM_REG_SEQUENCER_STATS_EN.
module ym_reg_sequencer
  import ym_seq_pkg::*;
#(
  parameter int CLK_IN_HZ  = 100000000,
  parameter int TICK_HZ    = 50,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_wait,
  input  logic [15:0]                 cmd_payload,
  input  logic                        enable,
  input  logic                        flush,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  wb_adr,
  output logic [31:0]                 wb_dat_w,
  output logic [3:0]                  wb_sel,
  output logic                        wb_cyc,
  output logic                        wb_stb,
  output logic                        wb_we,
  input  logic                        wb_ack,
  input  logic                        wb_err,
  input  logic                        wb_stall,
  output logic [15:0]                 wr_count,
  output logic [7:0]                  err_count
);

  localparam int DIV = CLK_IN_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;

  if (DIV < 2) begin : g_div_check
    $error("ym_reg_sequencer: CLK_IN_HZ/TICK_HZ must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("ym_reg_sequencer: FIFO_DEPTH must be a power of two >= 2");
  end

  cmd_t          head;
  cmd_t          push_ent;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic [LW-1:0] level_nxt;

  seq_state_e    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [15:0]   wait_cnt_q, wait_cnt_d;
  logic [7:0]    wb_adr_q, wb_adr_d;
  logic [7:0]    wb_dat_q, wb_dat_d;
  logic          wb_cyc_q, wb_cyc_d;
  logic          wb_stb_q, wb_stb_d;
  logic          wb_we_q, wb_we_d;
  logic          cmd_ready_q, cmd_ready_d;

  // A push coinciding with flush is dropped even though the producer sees it accepted.
  assign push_ent  = '{is_wait: cmd_wait, payload: cmd_payload};
  assign fifo_push = cmd_valid && cmd_ready_q && !flush;

  ym_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_dat  (push_ent),
    .pop       (fifo_pop),
    .flush     (flush),
    .head      (head),
    .level     (fifo_level),
    .level_nxt (level_nxt),
    .empty     (fifo_empty)
  );

  // Prescaler parks at 0 while disabled so the first tick is a full period after enable.
  always_comb begin
    presc_d = '0;
    tick    = 1'b0;
    if (enable) begin
      if (presc_q == PW'(DIV - 1)) begin
        tick = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wb_adr_d   = wb_adr_q;
    wb_dat_d   = wb_dat_q;
    wb_cyc_d   = wb_cyc_q;
    wb_stb_d   = wb_stb_q;
    wb_we_d    = wb_we_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && !fifo_empty && !flush) begin
          fifo_pop = 1'b1;
          if (!head.is_wait) begin
            wb_adr_d = head.payload[15:8];
            wb_dat_d = head.payload[7:0];
            wb_cyc_d = 1'b1;
            wb_stb_d = 1'b1;
            wb_we_d  = 1'b1;
            state_d  = WB_REQ;
          end else if (head.payload != 16'd0) begin
            wait_cnt_d = head.payload;
            state_d    = WAIT_TICKS;
          end
        end
      end
      WB_REQ: begin
        if (!wb_stall) begin
          wb_stb_d = 1'b0;
          if (wb_ack || wb_err) begin
            wb_cyc_d = 1'b0;
            wb_we_d  = 1'b0;
            state_d  = IDLE;
          end else begin
            state_d = WB_WAIT;
          end
        end
      end
      WB_WAIT: begin
        if (wb_ack || wb_err) begin
          wb_cyc_d = 1'b0;
          wb_we_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      WAIT_TICKS: begin
        if (flush) begin
          wait_cnt_d = '0;
          state_d    = IDLE;
        end else if (tick) begin
          wait_cnt_d = wait_cnt_q - 16'd1;
          if (wait_cnt_q == 16'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Derived from next occupancy, so a push that fills the FIFO closes it on the same edge.
  assign cmd_ready_d = (level_nxt < LW'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      wait_cnt_q  <= '0;
      wb_adr_q    <= '0;
      wb_dat_q    <= '0;
      wb_cyc_q    <= 1'b0;
      wb_stb_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      wait_cnt_q  <= wait_cnt_d;
      wb_adr_q    <= wb_adr_d;
      wb_dat_q    <= wb_dat_d;
      wb_cyc_q    <= wb_cyc_d;
      wb_stb_q    <= wb_stb_d;
      wb_we_q     <= wb_we_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign wb_adr    = wb_adr_q;
  assign wb_dat_w  = {24'd0, wb_dat_q};
  assign wb_sel    = wb_cyc_q ? WB_SEL_BYTE0 : 4'b0000;
  assign wb_cyc    = wb_cyc_q;
  assign wb_stb    = wb_stb_q;
  assign wb_we     = wb_we_q;

`ifdef YM_REG_SEQUENCER_STATS_EN
  logic        term;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  // A cycle terminates in WB_WAIT, or in WB_REQ on the unstalled beat; err wins over ack.
  always_comb begin
    term      = (state_q == WB_WAIT) || (state_q == WB_REQ && !wb_stall);
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    if (term && wb_err) begin
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end else if (term && wb_ack) begin
      if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign wr_count  = wr_cnt_q;
  assign err_count = err_cnt_q;
`else
  assign wr_count  = 16'd0;
  assign err_count = 8'd0;
`endif

endmodule
